pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register. It is the generic successor to the fixed per-stage latch banks (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Carries an opaque data payload plus a control field. Control bits are forced to zero whenever the stage holds a bubble.
- Adds a valid/ready handshake, flush, an optional 2-entry skid buffer, and a saturating stall-cycle counter for performance monitoring.
- Sits between any two CPU pipeline stages; one instance per stage boundary.

---
 rtl/pipe_stage_reg.sv | 165 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;

    generate
        if (SKID == 0) begin : g_single
            logic              valid_q, valid_d;
            logic [DATA_W-1:0] data_q, data_d;
            logic [CTRL_W-1:0] ctrl_q, ctrl_d;
            logic              accept, pop;

            assign in_ready = out_ready | ~valid_q;
            assign accept   = in_valid & in_ready & ~flush;
            assign pop      = valid_q & out_ready;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                ctrl_d  = ctrl_q;
                if (accept) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                    ctrl_d  = in_ctrl;
                end else if (pop) begin
                    valid_d = 1'b0;
                end
                if (flush) valid_d = 1'b0;
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    ctrl_q  <= ctrl_d;
                end
            end

            assign head_valid = valid_q;
            assign head_data  = data_q;
            assign head_ctrl  = ctrl_q;
        end else begin : g_skid
            state_t            state_q, state_d;
            logic              in_ready_q;
            logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
            logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
            logic              accept, pop;

            assign in_ready = in_ready_q;
            assign accept   = in_valid & in_ready_q & ~flush;
            assign pop      = (state_q != ST_EMPTY) & out_ready;

            always_comb begin
                state_d     = state_q;
                main_data_d = main_data_q;
                main_ctrl_d = main_ctrl_q;
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            state_d     = ST_ONE;
                            main_data_d = in_data;
                            main_ctrl_d = in_ctrl;
                        end
                    end
                    ST_ONE: begin
                        if (accept && pop) begin
                            main_data_d = in_data;
                            main_ctrl_d = in_ctrl;
                        end else if (accept) begin
                            state_d     = ST_FULL;
                            skid_data_d = in_data;
                            skid_ctrl_d = in_ctrl;
                        end else if (pop) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (pop) begin
                            state_d     = ST_ONE;
                            main_data_d = skid_data_q;
                            main_ctrl_d = skid_ctrl_q;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                if (flush) state_d = ST_EMPTY;
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    main_data_q <= '0;
                    main_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    state_q     <= state_d;
                    in_ready_q  <= (state_d != ST_FULL);
                    main_data_q <= main_data_d;
                    main_ctrl_q <= main_ctrl_d;
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                end
            end

            assign head_valid = (state_q != ST_EMPTY);
            assign head_data  = main_data_q;
            assign head_ctrl  = main_ctrl_q;
        end
    endgenerate

    // A bubble must never present live control bits downstream.
    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign out_ctrl  = head_valid ? head_ctrl : '0;

    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (stall_clr)
            stall_d = '0;
        else if (head_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: single-register stage, skid-buffer stage and a 4-bit counter stage.
module tb_pipe_stage_reg;

    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // a: SKID=0 CNT_W=16, b: SKID=1, c: SKID=0 CNT_W=4
    logic        a_flush, a_iv, a_ir, a_ov, a_or, a_clr;
    logic [31:0] a_id, a_od;
    logic [2:0]  a_ic, a_oc;
    logic [15:0] a_cnt;

    logic        b_flush, b_iv, b_ir, b_ov, b_or, b_clr;
    logic [31:0] b_id, b_od;
    logic [2:0]  b_ic, b_oc;
    logic [15:0] b_cnt;

    logic        c_flush, c_iv, c_ir, c_ov, c_or, c_clr;
    logic [31:0] c_id, c_od;
    logic [2:0]  c_ic, c_oc;
    logic [3:0]  c_cnt;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(0), .CNT_W(16)) u_a (
        .CLK(clk), .RST_N(rst_n), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .in_ctrl(a_ic), .out_valid(a_ov), .out_ready(a_or),
        .out_data(a_od), .out_ctrl(a_oc), .stall_cnt(a_cnt), .stall_clr(a_clr));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(1), .CNT_W(16)) u_b (
        .CLK(clk), .RST_N(rst_n), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .in_ctrl(b_ic), .out_valid(b_ov), .out_ready(b_or),
        .out_data(b_od), .out_ctrl(b_oc), .stall_cnt(b_cnt), .stall_clr(b_clr));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(0), .CNT_W(4)) u_c (
        .CLK(clk), .RST_N(rst_n), .flush(c_flush), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .in_ctrl(c_ic), .out_valid(c_ov), .out_ready(c_or),
        .out_data(c_od), .out_ctrl(c_oc), .stall_cnt(c_cnt), .stall_clr(c_clr));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_stream [3];

    initial begin
        exp_stream[0] = 32'h0040_0000;
        exp_stream[1] = 32'h0040_0004;
        exp_stream[2] = 32'h0040_0008;

        rst_n = 1'b0;
        {a_flush, a_iv, a_or, a_clr} = '0; a_id = '0; a_ic = '0;
        {b_flush, b_iv, b_or, b_clr} = '0; b_id = '0; b_ic = '0;
        {c_flush, c_iv, c_or, c_clr} = '0; c_id = '0; c_ic = '0;
        tick();
        check("rst_a_ov", a_ov, 0);
        check("rst_a_oc", a_oc, 0);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_a_ir", a_ir, 1);
        check("rst_b_ir", b_ir, 1);
        check("rst_b_ov", b_ov, 0);
        rst_n = 1'b1;

        // Stream three PCs through the single-register stage
        a_or = 1'b1; a_iv = 1'b1; a_ic = 3'b011;
        for (int i = 0; i < 3; i++) begin
            a_id = exp_stream[i];
            tick();
            check($sformatf("stream_ov%0d", i), a_ov, 1);
            check($sformatf("stream_od%0d", i), a_od, exp_stream[i]);
            check($sformatf("stream_oc%0d", i), a_oc, 3'b011);
        end
        a_iv = 1'b0;
        tick();
        check("stream_drain_ov", a_ov, 0);
        check("stream_drain_oc", a_oc, 0);

        // Stall with 0xDEADBEEF latched
        a_iv = 1'b1; a_id = 32'hDEAD_BEEF; a_or = 1'b0;
        tick();
        a_iv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stall_od%0d", i), a_od, 32'hDEAD_BEEF);
            check($sformatf("stall_ir%0d", i), a_ir, 0);
        end
        check("stall_cnt4", a_cnt, 4);
        a_or = 1'b1;
        #1;
        check("stall_ir_comb", a_ir, 1);
        tick();
        check("stall_pop_ov", a_ov, 0);
        check("stall_cnt_hold", a_cnt, 4);

        // Flush with control gating
        a_iv = 1'b1; a_id = 32'h11; a_ic = 3'b101;
        tick();
        check("flush_pre_oc", a_oc, 3'b101);
        a_flush = 1'b1; a_id = 32'h55; a_ic = 3'b111; a_or = 1'b0;
        tick();
        check("flush_ov", a_ov, 0);
        check("flush_oc", a_oc, 0);
        a_flush = 1'b0; a_iv = 1'b0;
        tick();
        check("flush_no55_ov", a_ov, 0);

        // Skid buffer: A, B, C with one-cycle downstream stall
        b_iv = 1'b1; b_id = 32'h1; b_ic = 3'b001; b_or = 1'b1;
        tick();
        check("skid_A_head", b_od, 32'h1);
        b_or = 1'b0; b_id = 32'h2; b_ic = 3'b010;
        tick();
        check("skid_A_held", b_od, 32'h1);
        check("skid_full_ir", b_ir, 0);
        b_or = 1'b1; b_id = 32'h3; b_ic = 3'b011;
        tick();
        check("skid_B_head", b_od, 32'h2);
        check("skid_B_oc", b_oc, 3'b010);
        check("skid_one_ir", b_ir, 1);
        tick();
        check("skid_C_head", b_od, 32'h3);
        check("skid_C_ov", b_ov, 1);
        b_iv = 1'b0;
        tick();
        check("skid_empty_ov", b_ov, 0);
        check("skid_cnt", b_cnt, 1);

        // 4-bit counter saturation and clear
        c_iv = 1'b1; c_id = 32'h77; c_or = 1'b0;
        tick();
        c_iv = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt15", c_cnt, 15);
        c_clr = 1'b1;
        tick();
        check("clr_cnt0", c_cnt, 0);
        c_clr = 1'b0;
        tick();
        check("clr_cnt1", c_cnt, 1);

        // Asynchronous reset with the skid stage FULL
        b_iv = 1'b1; b_id = 32'h10; b_or = 1'b0;
        tick();
        b_id = 32'h20;
        tick();
        check("arst_pre_ir", b_ir, 0);
        check("arst_pre_ov", b_ov, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ov", b_ov, 0);
        check("arst_oc", b_oc, 0);
        check("arst_ir", b_ir, 1);
        #1 rst_n = 1'b1;
        b_id = 32'h30; b_ic = 3'b110; b_or = 1'b1;
        tick();
        check("arst_first_ov", b_ov, 1);
        check("arst_first_od", b_od, 32'h30);
        check("arst_first_oc", b_oc, 3'b110);
        b_iv = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
